// File: rtl/seq_log_unit.sv
// Iterative fixed-point logarithm: normalise, then square the mantissa once per result bit.
// The log2 value is scaled to ln or log10 with one rounded Q0.32 constant multiply.
module seq_log_unit #(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned FRAC_W  = 16,
  parameter int unsigned GUARD_W = 4,
  localparam int unsigned RES_W  = 8 + FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned MF    = FRAC_W + GUARD_W;
  localparam int unsigned MW    = MF + 1;
  localparam int unsigned SqW   = MF + 2;
  localparam int unsigned ProdW = RES_W + 32;
  localparam int unsigned CW    = $clog2(FRAC_W + 1);

  localparam logic [31:0]      LnTwo    = 32'd2977044472;
  localparam logic [31:0]      LgTwo    = 32'd1292913986;
  localparam logic [ProdW-1:0] RndHalf  = ProdW'(64'h8000_0000);

  typedef enum logic [2:0] {StIdle, StNorm, StIter, StScale, StDone} state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     x_q, x_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          k_q, k_d;
  logic [MW-1:0]       y_q, y_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [RES_W-1:0]    data_q, data_d;
  logic                oerr_q, oerr_d;

  logic [7:0]          lead;
  logic [7:0]          shamt;
  logic [IN_W-1:0]     x_norm;
  logic [MW-1:0]       y_norm;
  logic [2*MW-1:0]     y_w;
  logic [SqW-1:0]      sq_t;
  logic                sq_hi;
  logic [MW-1:0]       y_next;
  logic [RES_W-1:0]    l_val;
  logic [ProdW-1:0]    l_w;
  logic [ProdW-1:0]    c_w;
  logic [RES_W-1:0]    scaled;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (x_q[i]) lead = 8'(i);
    end
    shamt  = 8'(IN_W - 1) - lead;
    x_norm = x_q << shamt;
    // Leading one lands on the integer bit of Q1.MF; lower operand bits fall off.
    y_norm = MW'({x_norm, {MF{1'b0}}} >> (IN_W - 1));

    y_w    = {{MW{1'b0}}, y_q};
    sq_t   = SqW'((y_w * y_w) >> MF);
    sq_hi  = sq_t[SqW-1];
    y_next = sq_hi ? sq_t[SqW-1:1] : sq_t[MF:0];

    l_val  = {k_q, frac_q};
    l_w    = ProdW'(l_val);
    c_w    = ProdW'((mode_q == 2'b01) ? LnTwo : LgTwo);
    scaled = (mode_q == 2'b00) ? l_val : RES_W'((l_w * c_w + RndHalf) >> 32);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    k_d     = k_q;
    y_d     = y_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    oerr_d  = oerr_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_data;
          mode_d  = in_mode;
          state_d = StNorm;
        end
      end
      StNorm: begin
        // Errors also pass through StScale so their latency is a fixed two edges.
        if (x_q == '0 || mode_q == 2'b11) begin
          err_d   = 1'b1;
          state_d = StScale;
        end else begin
          err_d   = 1'b0;
          k_d     = lead;
          y_d     = y_norm;
          frac_d  = '0;
          cnt_d   = CW'(FRAC_W);
          state_d = StIter;
        end
      end
      StIter: begin
        frac_d = {frac_q[FRAC_W-2:0], sq_hi};
        y_d    = y_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = StScale;
      end
      StScale: begin
        data_d  = err_q ? '0 : scaled;
        oerr_d  = err_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      mode_q  <= '0;
      k_q     <= '0;
      y_q     <= '0;
      frac_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      y_q     <= y_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      oerr_q  <= oerr_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = data_q;
  assign out_err   = oerr_q;

endmodule
